// File: rtl/imem_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// ifetch_pkg
// Shared types and constants for the instruction fetch front end.
//   fetch_state_t : request FSM states (IDLE, FETCH, DISCARD)
//   fetch_entry_t : one prefetch queue entry {pc, instr}
//   NOP_INSTR_C   : addi x0,x0,0, shown on Instr_F when nothing valid
//   word_align()  : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/imem_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// imem_fetch_unit_if
// Instruction memory request/response bus between the fetch unit (master)
// and instruction memory (slave). At most one request is outstanding; the
// address is held while imem_req=1 until the imem_ack cycle.
//   imem_req   : request valid (master -> slave)
//   imem_addr  : word-aligned request address (master -> slave)
//   imem_ack   : response valid, imem_rdata valid this cycle (slave -> master)
//   imem_rdata : returned instruction word (slave -> master)
// -----------------------------------------------------------------------------
interface imem_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/imem_fetch_unit_fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// DEPTH-entry synchronous FIFO of fetch_entry_t used as the prefetch queue.
// Head is read combinationally from the storage registers.
//   clk, reset : clock, asynchronous active-low reset
//   push, din  : write din at the tail
//   pop        : drop the head entry
//   clear      : flush (wins over push/pop)
//   full, empty, count : occupancy (count is log2(DEPTH)+1 bits)
//   head       : oldest entry
// -----------------------------------------------------------------------------
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count,
    output fetch_entry_t head
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;

    // Storage needs no reset: nothing is read out while the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = mem[rd_ptr_reg];

    // The fetch FSM only requests while space remains, so a push into a
    // full queue without a simultaneous pop means the FSM is broken.
    always @(posedge clk) begin
        if (reset) begin
            assert (!(push && full && !pop && !clear));
        end
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// imem_fetch_unit
// Fetch front end: owns the fetch PC, issues one-at-a-time word requests to
// instruction memory, buffers returned words in a prefetch queue and presents
// the head to the decode pipeline register.
//   clk, reset      : clock, asynchronous active-low reset
//   PCSrc/PCTargetE : redirect request and target from execute
//   StallF          : decode not accepting this cycle
//   imem            : instruction memory bus (master modport)
//   Instr_F/PCF/PCPlus4_F/InstrValidF : head instruction view
//   FetchEmpty      : prefetch queue empty (fetch bubble)
// Optional macro IFETCH_BYPASS_EN: with an empty queue, a returning word is
// shown in its ack cycle and, if not stalled, consumed without being queued.
// -----------------------------------------------------------------------------
module imem_fetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCSrc,
    input  logic [31:0]        PCTargetE,
    input  logic               StallF,
    imem_fetch_unit_if.master  imem,
    output logic [31:0]        Instr_F,
    output logic [31:0]        PCF,
    output logic [31:0]        PCPlus4_F,
    output logic               InstrValidF,
    output logic               FetchEmpty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    fetch_state_t state_reg, state_next;
    logic [31:0]  fetch_pc_reg, fetch_pc_next;
    logic [31:0]  addr_reg, addr_next;

    logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [AW:0]  fifo_count, count_after;
    fetch_entry_t fifo_head, fifo_din;
    logic         ack_take, bypass_hit;

    // A response is only kept when it answers a live request and no redirect
    // arrives in the same cycle.
    assign ack_take = (state_reg == FETCH) && imem.imem_ack && !PCSrc;

`ifdef IFETCH_BYPASS_EN
    assign bypass_hit = fifo_empty && ack_take;
`else
    assign bypass_hit = 1'b0;
`endif

    // A redirect flushes the queue, so any pop in that cycle is meaningless.
    assign fifo_pop    = !fifo_empty && !StallF && !PCSrc;
    assign fifo_push   = ack_take && !(bypass_hit && !StallF);
    assign fifo_din    = '{pc: fetch_pc_reg, instr: imem.imem_rdata};
    assign count_after = fifo_count + (AW+1)'(fifo_push) - (AW+1)'(fifo_pop);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (PCSrc),
        .din   (fifo_din),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .head  (fifo_head)
    );

    // addr_reg only changes when a new request starts, which keeps the bus
    // address stable through DISCARD even though fetch_pc has moved on.
    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        addr_next     = addr_reg;
        unique case (state_reg)
            IDLE: begin
                if (PCSrc) begin
                    fetch_pc_next = PCTargetE;
                end else if (!fifo_full) begin
                    state_next = FETCH;
                    addr_next  = word_align(fetch_pc_reg);
                end
            end
            FETCH: begin
                if (imem.imem_ack) begin
                    if (PCSrc) begin
                        fetch_pc_next = PCTargetE;
                        state_next    = IDLE;
                    end else begin
                        fetch_pc_next = fetch_pc_reg + 32'd4;
                        if (count_after < DEPTH_C) begin
                            state_next = FETCH;
                            addr_next  = word_align(fetch_pc_reg + 32'd4);
                        end else begin
                            state_next = IDLE;
                        end
                    end
                end else if (PCSrc) begin
                    fetch_pc_next = PCTargetE;
                    state_next    = DISCARD;
                end
            end
            DISCARD: begin
                if (PCSrc) fetch_pc_next = PCTargetE;
                if (imem.imem_ack) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            addr_reg     <= word_align(RESET_PC);
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            addr_reg     <= addr_next;
        end
    end

    // With an empty queue PCF shows fetch_pc, i.e. the next expected PC.
    always_comb begin
        InstrValidF = !fifo_empty || bypass_hit;
        if (!fifo_empty) begin
            Instr_F = fifo_head.instr;
            PCF     = fifo_head.pc;
        end else if (bypass_hit) begin
            Instr_F = imem.imem_rdata;
            PCF     = fetch_pc_reg;
        end else begin
            Instr_F = NOP_INSTR;
            PCF     = fetch_pc_reg;
        end
    end

    assign PCPlus4_F      = PCF + 32'd4;
    assign FetchEmpty     = fifo_empty;
    assign imem.imem_req  = (state_reg != IDLE);
    assign imem.imem_addr = addr_reg;

endmodule

// File: tb/tb_imem_fetch_unit.sv
`timescale 1ns/1ps
module tb_imem_fetch_unit;
    import ifetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic        StallF = 1'b0;
    logic [31:0] Instr_F, PCF, PCPlus4_F;
    logic        InstrValidF, FetchEmpty;

    imem_fetch_unit_if bus();

    imem_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .DEPTH     (4),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrc       (PCSrc),
        .PCTargetE   (PCTargetE),
        .StallF      (StallF),
        .imem        (bus),
        .Instr_F     (Instr_F),
        .PCF         (PCF),
        .PCPlus4_F   (PCPlus4_F),
        .InstrValidF (InstrValidF),
        .FetchEmpty  (FetchEmpty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int lat_cnt  = 0;
    int n_req    = 0;
    logic found, seen8, got;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory answering in the same cycle as the request.
    task automatic resp0();
        bus.imem_ack   = bus.imem_req;
        bus.imem_rdata = mem_word(bus.imem_addr);
        #1;
    endtask

    // Memory answering in the third cycle of a request.
    task automatic resp_lat3();
        if (bus.imem_req) begin
            if (lat_cnt == 2) begin
                bus.imem_ack = 1'b1;
                lat_cnt = 0;
            end else begin
                bus.imem_ack = 1'b0;
                lat_cnt++;
            end
        end else begin
            bus.imem_ack = 1'b0;
            lat_cnt = 0;
        end
        bus.imem_rdata = mem_word(bus.imem_addr);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        PCSrc = 1'b0;
        StallF = 1'b0;
        bus.imem_ack = 1'b0;
        lat_cnt = 0;
        #1;
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        #2;
        // Reset values
        chk("rst_req",   bus.imem_req, 0);
        chk("rst_valid", InstrValidF, 0);
        chk("rst_empty", FetchEmpty, 1);
        chk("rst_instr", Instr_F, 32'h0000_0013);
        chk("rst_pcf",   PCF, 32'h0);
        chk("rst_pcp4",  PCPlus4_F, 32'h4);

        // 1: same-cycle ack, back-to-back fetches
        apply_reset();
        resp0();
        chk("t1_idle_req", bus.imem_req, 0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            resp0();
            chk("t1_req", bus.imem_req, 1);
            chk("t1_addr", bus.imem_addr, 32'(4*k));
`ifdef IFETCH_BYPASS_EN
            chk("t1_valid", InstrValidF, 1);
            chk("t1_instr", Instr_F, mem_word(32'(4*k)));
            chk("t1_pcf", PCF, 32'(4*k));
            chk("t1_pcp4", PCPlus4_F, 32'(4*k+4));
`else
            if (k > 0) begin
                chk("t1_valid", InstrValidF, 1);
                chk("t1_instr", Instr_F, mem_word(32'(4*(k-1))));
                chk("t1_pcf", PCF, 32'(4*(k-1)));
                chk("t1_pcp4", PCPlus4_F, 32'(4*k));
            end else begin
                chk("t1_valid0", InstrValidF, 0);
            end
`endif
            cyc();
        end

        // 2: stall fills the queue, then drains in order
        apply_reset();
        StallF = 1'b1;
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            resp0();
            if (bus.imem_req) n_req++;
            cyc();
        end
        resp0();
        chk("t2_req_off", bus.imem_req, 0);
        chk("t2_nreq", n_req, 4);
        chk("t2_empty", FetchEmpty, 0);
        chk("t2_pcf0", PCF, 32'h0);
        StallF = 1'b0;
        for (int j = 0; j < 6; j++) begin
            resp0();
            chk("t2_valid", InstrValidF, 1);
            chk("t2_pcf", PCF, 32'(4*j));
            chk("t2_instr", Instr_F, mem_word(32'(4*j)));
            cyc();
        end

        // 3: redirect while request to 0x8 pending (latency 3)
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            resp_lat3();
            if (bus.imem_req && bus.imem_addr == 32'h8) found = 1'b1;
        end
        chk("t3_req8", found, 1);
        PCSrc = 1'b1;
        PCTargetE = 32'h100;
        cyc();
        PCSrc = 1'b0;
        resp_lat3();
        chk("t3_hold_req", bus.imem_req, 1);
        chk("t3_hold_addr", bus.imem_addr, 32'h8);
        chk("t3_empty", FetchEmpty, 1);
        chk("t3_valid0", InstrValidF, 0);
        found = 1'b0;
        seen8 = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            resp_lat3();
            if (InstrValidF && PCF == 32'h8) seen8 = 1'b1;
            if (bus.imem_req && bus.imem_addr == 32'h100) found = 1'b1;
        end
        chk("t3_req100", found, 1);
        chk("t3_no8", seen8, 0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            cyc();
            resp_lat3();
            if (InstrValidF) got = 1'b1;
        end
        chk("t3_got", got, 1);
        chk("t3_pcf", PCF, 32'h100);
        chk("t3_instr", Instr_F, mem_word(32'h100));

        // 4: redirect coinciding with ack and pop
        apply_reset();
        resp0();
        cyc();
        resp0();
        cyc();
        PCSrc = 1'b1;
        PCTargetE = 32'h40;
        resp0();
        chk("t4_ack_addr", bus.imem_addr, 32'h4);
        cyc();
        PCSrc = 1'b0;
        resp0();
        chk("t4_empty", FetchEmpty, 1);
        chk("t4_valid", InstrValidF, 0);
        chk("t4_req", bus.imem_req, 0);
        chk("t4_pcf", PCF, 32'h40);
        chk("t4_instr", Instr_F, 32'h0000_0013);
        cyc();
        resp0();
        chk("t4_req40", bus.imem_req, 1);
        chk("t4_addr40", bus.imem_addr, 32'h40);

        // 5: asynchronous reset with three entries queued
        apply_reset();
        StallF = 1'b1;
        for (int i = 0; i < 4; i++) begin
            resp0();
            cyc();
        end
        bus.imem_ack = 1'b0;
        #1;
        chk("t5_req", bus.imem_req, 1);
        chk("t5_addr", bus.imem_addr, 32'hC);
        chk("t5_empty", FetchEmpty, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_rst_req", bus.imem_req, 0);
        chk("t5_rst_valid", InstrValidF, 0);
        chk("t5_rst_empty", FetchEmpty, 1);
        chk("t5_rst_instr", Instr_F, 32'h0000_0013);
        chk("t5_rst_pcf", PCF, 32'h0);
        chk("t5_rst_pcp4", PCPlus4_F, 32'h4);
        cyc();
        reset = 1'b1;
        StallF = 1'b0;
        resp0();
        chk("t5_idle", bus.imem_req, 0);
        cyc();
        resp0();
        chk("t5_req0", bus.imem_req, 1);
        chk("t5_addr0", bus.imem_addr, 32'h0);

        // 6: PC wrap at the top of the address space
        apply_reset();
        PCSrc = 1'b1;
        PCTargetE = 32'hFFFF_FFFC;
        resp0();
        cyc();
        PCSrc = 1'b0;
        resp0();
        chk("t6_pcf", PCF, 32'hFFFF_FFFC);
        chk("t6_pcp4", PCPlus4_F, 32'h0);
        chk("t6_req0", bus.imem_req, 0);
        cyc();
        resp0();
        chk("t6_req", bus.imem_req, 1);
        chk("t6_addr", bus.imem_addr, 32'hFFFF_FFFC);
`ifdef IFETCH_BYPASS_EN
        chk("t6_byp_valid", InstrValidF, 1);
        chk("t6_byp_pcf", PCF, 32'hFFFF_FFFC);
        chk("t6_byp_pcp4", PCPlus4_F, 32'h0);
        chk("t6_byp_instr", Instr_F, mem_word(32'hFFFF_FFFC));
`else
        chk("t6_nobyp", InstrValidF, 0);
`endif
        cyc();
        resp0();
        chk("t6_wrap_addr", bus.imem_addr, 32'h0);
`ifdef IFETCH_BYPASS_EN
        chk("t6_byp2_pcf", PCF, 32'h0);
        chk("t6_byp2_instr", Instr_F, mem_word(32'h0));
`else
        chk("t6_valid", InstrValidF, 1);
        chk("t6_pcf_q", PCF, 32'hFFFF_FFFC);
        chk("t6_pcp4_q", PCPlus4_F, 32'h0);
`endif
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Fetch front end sitting directly upstream of the pipelined datapath.
- Owns the fetch PC and issues word requests to instruction memory over a variable-latency req/ack handshake.
- Buffers returned instructions in a small prefetch queue and presents the head as Instr_F/PCF/PCPlus4_F to the decode pipeline register.
- Honours StallF and branch/jump redirects (PCSrc, PCTargetE) from the datapath.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.
- NOP_INSTR, 32'h0000_0013, instruction driven on Instr_F when no valid entry (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- PCSrc  in  1  redirect request from execute stage.
- PCTargetE  in  32  redirect target.
- StallF  in  1  consumer not accepting this cycle.
- imem_req  out  1  request valid.
- imem_addr  out  32  word-aligned request address.
- imem_ack  in  1  response; imem_rdata valid this cycle.
- imem_rdata  in  32  returned instruction.
- Instr_F  out  32  head instruction, or NOP_INSTR.
- PCF  out  32  PC of head instruction.
- PCPlus4_F  out  32  PCF+4.
- InstrValidF  out  1  head entry valid.
- FetchEmpty  out  1  queue empty; the hazard unit treats this as a fetch bubble.

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, queue empty, fetch_pc=RESET_PC, imem_req=0, InstrValidF=0, FetchEmpty=1, Instr_F=NOP_INSTR, PCF=RESET_PC, PCPlus4_F=RESET_PC+4.
- At most one outstanding memory request.
- imem_addr = fetch_pc, with bits [1:0] forced to 0.
- While imem_req=1, imem_addr is held stable until the imem_ack cycle.
- FSM states: IDLE, FETCH, DISCARD.
  - IDLE -> FETCH when count < DEPTH and PCSrc=0. Set imem_req=1.
  - FETCH, ack=1, no redirect: push {fetch_pc, imem_rdata}; fetch_pc += 4. Then go to FETCH if space remains after the push and pop (back-to-back, one request per cycle max), otherwise IDLE.
  - FETCH, ack=0, PCSrc=1: go to DISCARD. Keep req and addr stable. Load fetch_pc=PCTargetE.
  - FETCH, ack=1, PCSrc=1 in the same cycle: drop rdata, load fetch_pc=PCTargetE, go to IDLE.
  - DISCARD, ack=1: drop rdata, go to IDLE.
  - DISCARD, PCSrc=1 again: reload fetch_pc=PCTargetE and stay in DISCARD.
- Pop: the head is consumed when InstrValidF=1 and StallF=0.
- Push and pop in the same cycle keep count unchanged. A push into a full queue is impossible by construction; an assertion checks it.
- Redirect (PCSrc=1): in the same edge, clear the queue and discard any pop.
  - InstrValidF=0 in the following cycle until the target instruction returns.
  - PCSrc has priority over push, pop and StallF.
- Output: Instr_F, PCF and InstrValidF come from the queue head, combinationally from registered state.
  - Empty queue: Instr_F=NOP_INSTR, PCF = PC of the next expected instruction.
- PCPlus4_F = PCF + 32'd4, modulo 2^32. Wrap at 32'hFFFF_FFFC gives 0.
- Queue pointers are log2(DEPTH) bits with wrap. count is log2(DEPTH)+1 bits.
- StallF held high with a full queue: FSM idles with no requests. Contents are preserved.
- Minimum latency: request issued in cycle N, ack in cycle N gives InstrValidF=1 in N+1.

Optional Feature:
- Macro: IFETCH_BYPASS_EN.
- Defined: when the queue is empty and imem_ack=1 with no redirect, Instr_F=imem_rdata, PCF=fetch_pc and InstrValidF=1 in the same cycle.
  - If StallF=0, the entry is consumed without being pushed.
  - If StallF=1, it is pushed normally.
- Not defined: data always goes through the queue, with one cycle minimum ack-to-output latency. Outputs are purely registered-state driven.

Decomposition:
- Package ifetch_pkg holds:
  - typedef enum logic [1:0] fetch_state_t {IDLE, FETCH, DISCARD}.
  - typedef struct packed fetch_entry_t {pc[31:0], instr[31:0]}.
  - localparam NOP_INSTR_C = 32'h0000_0013.
- One sub-module, fetch_fifo: a parameterised DEPTH x fetch_entry_t synchronous FIFO.
  - Signals: push, pop, clear, full, empty, count, head.
  - Asynchronous active-low reset.
- The FSM, fetch_pc and redirect logic live in imem_fetch_unit.

Test Plan:
- Reset release, ack returned the same cycle as each req, StallF=0 -> addresses 0x0, 0x4, 0x8 issued back-to-back. Instr_F shows each word one cycle after its ack, with InstrValidF=1 and PCPlus4_F=PCF+4.
- StallF=1 for 10 cycles -> exactly 4 entries buffered, then imem_req=0. Releasing StallF delivers PCs 0x0, 0x4, 0x8, 0xC in order with no loss.
- Ack latency 3 cycles, PCSrc=1 with PCTargetE=0x100 while a request to 0x8 is pending -> the 0x8 data is dropped in DISCARD. The next request is to 0x100, and PCF=0x100 appears after its ack.
- PCSrc=1, PCTargetE=0x40 in the same cycle as an ack and a pop -> queue cleared and rdata dropped. FetchEmpty=1 next cycle, then the next imem_addr is 0x40.
- Assert reset low mid-request with the queue holding 3 entries -> all outputs at reset values immediately. After release, the first imem_addr is RESET_PC.
- PCTargetE=0xFFFF_FFFC -> PCPlus4_F=0x0 and the following request address is 0x0. With IFETCH_BYPASS_EN, an empty queue plus ack gives InstrValidF in the ack cycle.
